spi_shift_engine: RTL and testbench
===================================

// Module: spi_shift_engine
// PURPOSE
//  SPI master data path sitting directly downstream of the SPI clock generator.
//  Consumes its free-running SCK, aligns a transfer to it and drives SS_N/SCK_OUT/MOSI.
//  Shifts one DATA_WIDTH word out on MOSI while capturing MISO, honouring CPOL/CPHA.
//  Word handoff to the APB register block uses a valid/ready pair (TX) and a pulse (RX).
// PARAMETERS
//  DATA_WIDTH  8  bits per transfer (>=2)
//  LSB_FIRST   0  0: MSB shifted first, 1: LSB shifted first
// PORTS
//  PCLK      in   1           system clock, all logic on rising edge
//  PRESET    in   1           synchronous reset, active high
//  SPE       in   1           engine enable; 0 aborts any transfer
//  CPOL      in   1           SCK idle level (static while BUSY)
//  CPHA      in   1           0: sample leading/shift trailing, 1: shift leading/sample trailing
//  SCK_IN    in   1           free-running SCK from clock generator (PCLK-synchronous)
//  TX_DATA   in   DATA_WIDTH  word to transmit
//  TX_VALID  in   1           TX_DATA valid
//  TX_READY  out  1           engine accepts TX_DATA this cycle
//  RX_DATA   out  DATA_WIDTH  last received word, held until next completion
//  RX_VALID  out  1           one-cycle pulse, RX_DATA updated
//  BUSY      out  1           transfer in progress (state != IDLE)
//  SS_N      out  1           slave select, active low
//  SCK_OUT   out  1           gated SCK to pad
//  MOSI      out  1           serial data out
//  MISO      in   1           serial data in (PCLK-synchronous)
// BEHAVIOUR
//  Reset: state IDLE, SS_N=1, MOSI=0, RX_DATA=0, RX_VALID=0, BUSY=0, edge count 0, sck_q=sck_d=CPOL.
//  SCK_IN registered twice: sck_q <= SCK_IN, sck_d <= sck_q.
//   leading edge  = (sck_d==CPOL) && (sck_q!=CPOL); trailing = (sck_d!=CPOL) && (sck_q==CPOL).
//  SCK_OUT = sck_q in XFER, else CPOL (combinational mux on registered signals, glitch-free).
//  TX_READY = SPE && state==IDLE (combinational). Accept = TX_VALID && TX_READY.
//  FSM:
//   IDLE : on accept -> SYNC; load shift reg from TX_DATA, MOSI <= first bit, SS_N <= 0.
//   SYNC : wait until sck_q==CPOL (next edge is leading), then -> XFER, edge count 0.
//   XFER : count every leading/trailing edge; at 2*DATA_WIDTH-th edge -> DONE.
//   DONE : RX_DATA <= rx shift reg, RX_VALID=1 this cycle, SS_N <= 1, -> IDLE.
//  Sample edge (CPHA=0 leading, CPHA=1 trailing): MISO shifted into rx reg (MSB- or LSB-side per LSB_FIRST).
//  Shift edge (CPHA=0 trailing, CPHA=1 leading): MOSI advances to next bit, except
//   CPHA=1 first leading edge (bit 0 already on MOSI) and CPHA=0 final trailing edge.
//  MOSI holds last bit after final edge until next load; MOSI is not tri-stated.
//  Latency: accept -> SS_N low next cycle; last edge -> RX_VALID 1 cycle later; SS_N high >=1 cycle between words.
//  TX_VALID in DONE is not accepted; accepted on the following IDLE cycle.
//  SPE=0 in SYNC/XFER/DONE: -> IDLE next cycle, SS_N=1, no RX_VALID, RX_DATA unchanged.
//  SPE=0 in IDLE: TX_READY=0, no accept.
//  PRESET has priority over all; mid-transfer reset returns to reset values next cycle.
//  Edge counter width clog2(2*DATA_WIDTH+1); never wraps (leaves XFER at terminal count).
//  SCK_IN toggling every PCLK (fastest divider) is supported: one edge per cycle.
// TESTING
//  1. Mode 0, SCK_IN period 8 PCLK, TX 0xA5, MISO=MOSI loopback -> RX_DATA 0xA5, one RX_VALID, 16 SCK_OUT edges, SS_N low throughout.
//  2. Mode 3, slave model returns 0x3C, TX 0xC3 -> slave captures 0xC3 on trailing edges, RX_DATA 0x3C.
//  3. LSB_FIRST=1, mode 1, TX 0x01 -> MOSI high only for first bit period; loopback RX 0x01.
//  4. Mode 0, SPE dropped after 5th edge -> IDLE next cycle, SS_N=1, SCK_OUT=CPOL, no RX_VALID, RX_DATA keeps prior 0xA5.
//  5. TX_VALID held high with 0x11 then 0x22 -> two transfers, SS_N high >=1 cycle between, RX 0x11 then 0x22.
//  6. PRESET asserted mid-XFER (mode 2) -> next cycle SS_N=1, BUSY=0, MOSI=0, RX_DATA=0, SCK_OUT=1.

Source files
------------

// File: rtl/spi_shift_engine_if.sv
// Word handoff between the APB register block (master) and the SPI shift engine (slave).
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic [DATA_WIDTH-1:0] RX_DATA;
    logic                  RX_VALID;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY,
        input  RX_DATA,
        input  RX_VALID
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY,
        output RX_DATA,
        output RX_VALID
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master data path: aligns a word transfer to the free-running SCK from the clock
// generator, drives SS_N/SCK_OUT/MOSI and captures MISO for every CPOL/CPHA mode.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              SPE,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              SCK_IN,
    spi_shift_engine_if.slave word_if,
    output logic              BUSY,
    output logic              SS_N,
    output logic              SCK_OUT,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int                CNT_W     = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_EDGE = CNT_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        XFER,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_nxt;
    logic                    sck_q;
    logic                    sck_d;
    logic [CNT_W-1:0]        edge_cnt;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [DATA_WIDTH-1:0]   rx_hold;
    logic                    ss_n_q;
    logic                    accept;
    logic                    lead_edge;
    logic                    trail_edge;
    logic                    any_edge;
    logic                    sample_edge;
    logic                    shift_edge;
    logic                    shift_ok;
    logic                    in_xfer;
    logic                    rx_fire;

    assign word_if.TX_READY = SPE && (state_q == IDLE);
    assign accept           = word_if.TX_VALID && word_if.TX_READY;

    assign lead_edge   = (sck_d == CPOL) && (sck_q != CPOL);
    assign trail_edge  = (sck_d != CPOL) && (sck_q == CPOL);
    assign any_edge    = lead_edge || trail_edge;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign in_xfer     = SPE && (state_q == XFER);
    assign rx_fire     = SPE && (state_q == DONE);

    // Bit 0 is already on MOSI at the first CPHA=1 leading edge; with CPHA=0 the
    // final trailing edge has no next bit, so MOSI keeps the last bit.
    assign shift_ok = shift_edge
                      && !(CPHA && (edge_cnt == '0))
                      && !(!CPHA && (edge_cnt == LAST_EDGE));

    assign BUSY             = (state_q != IDLE);
    assign SS_N             = ss_n_q;
    assign SCK_OUT          = (state_q == XFER) ? sck_q : CPOL;
    assign MOSI             = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
    assign word_if.RX_VALID = rx_fire;
    assign word_if.RX_DATA  = rx_fire ? rx_shift : rx_hold;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: if (accept) state_nxt = SYNC;
            SYNC: if (sck_q == CPOL) state_nxt = XFER;
            XFER: if (any_edge && (edge_cnt == LAST_EDGE)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!SPE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sck_q    <= CPOL;
            sck_d    <= CPOL;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_hold  <= '0;
            ss_n_q   <= 1'b1;
        end else begin
            sck_q <= SCK_IN;
            sck_d <= sck_q;

            if (accept) begin
                tx_shift <= word_if.TX_DATA;
                ss_n_q   <= 1'b0;
            end

            if (state_q == SYNC) begin
                edge_cnt <= '0;
            end else if (in_xfer && any_edge) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end

            if (in_xfer && sample_edge) begin
                if (LSB_FIRST) begin
                    rx_shift <= {MISO, rx_shift[DATA_WIDTH-1:1]};
                end else begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
                end
            end

            if (in_xfer && shift_ok) begin
                if (LSB_FIRST) begin
                    tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end

            if (rx_fire) begin
                rx_hold <= rx_shift;
            end

            if ((state_q == DONE) || (!SPE && (state_q != IDLE))) begin
                ss_n_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Randomized bench for spi_shift_engine: an MSB-first and an LSB-first instance are
// driven from one stimulus stream and checked against a behavioural SPI slave model.
module tb_spi_shift_engine;

    localparam int DW = 8;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       SPE;
    logic       CPOL;
    logic       CPHA;
    logic       SCK_IN = 1'b0;
    logic       txv;
    logic [7:0] txd;
    bit         sel;
    bit         loopback;
    logic [7:0] slave_word;
    logic       miso_slave = 1'b0;
    int         half = 4;

    logic busy_m, ss_m, sck_m, mosi_m, miso_m;
    logic busy_l, ss_l, sck_l, mosi_l, miso_l;
    logic busy_o, ss_o, sck_o, mosi_o, ready_o, rxv_o;
    logic [7:0] rxd_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q [$];
    logic [7:0] slv_q [$];
    int         edge_q [$];
    int         gap_q [$];

    spi_shift_engine_if #(.DATA_WIDTH(DW)) if_m ();
    spi_shift_engine_if #(.DATA_WIDTH(DW)) if_l ();

    assign if_m.TX_DATA  = txd;
    assign if_l.TX_DATA  = txd;
    assign if_m.TX_VALID = txv && !sel;
    assign if_l.TX_VALID = txv && sel;
    assign miso_m        = loopback ? mosi_m : miso_slave;
    assign miso_l        = loopback ? mosi_l : miso_slave;

    spi_shift_engine #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut_m (
        .PCLK(PCLK), .PRESET(PRESET), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA),
        .SCK_IN(SCK_IN), .word_if(if_m), .BUSY(busy_m), .SS_N(ss_m),
        .SCK_OUT(sck_m), .MOSI(mosi_m), .MISO(miso_m)
    );

    spi_shift_engine #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_l (
        .PCLK(PCLK), .PRESET(PRESET), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA),
        .SCK_IN(SCK_IN), .word_if(if_l), .BUSY(busy_l), .SS_N(ss_l),
        .SCK_OUT(sck_l), .MOSI(mosi_l), .MISO(miso_l)
    );

    always #5 PCLK = ~PCLK;

    // Free-running SCK source: toggles every 'half' PCLK cycles, just after the edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge PCLK);
            #1;
            cnt++;
            if (cnt >= half) begin
                SCK_IN = ~SCK_IN;
                cnt    = 0;
            end
        end
    end

    always_comb begin
        busy_o  = busy_m;
        ss_o    = ss_m;
        sck_o   = sck_m;
        mosi_o  = mosi_m;
        ready_o = if_m.TX_READY;
        rxv_o   = if_m.RX_VALID;
        rxd_o   = if_m.RX_DATA;
        if (sel) begin
            busy_o  = busy_l;
            ss_o    = ss_l;
            sck_o   = sck_l;
            mosi_o  = mosi_l;
            ready_o = if_l.TX_READY;
            rxv_o   = if_l.RX_VALID;
            rxd_o   = if_l.RX_DATA;
        end
    end

    function automatic logic bitOf(input logic [7:0] w, input bit lsb, input int i);
        return lsb ? w[i] : w[7-i];
    endfunction

    // Behavioural SPI slave plus bus monitor, evaluated away from the active edge.
    logic       prev_ss = 1'b1;
    logic       prev_sck = 1'b0;
    int         edges = 0;
    int         nsamp = 0;
    int         sh = 0;
    int         gap_cnt = 0;
    bit         seen_rise = 1'b0;
    logic [7:0] slv_rx = 8'h00;

    always @(negedge PCLK) begin
        if (rxv_o === 1'b1) rx_q.push_back(rxd_o);
        if (prev_ss && !ss_o) begin
            if (seen_rise) gap_q.push_back(gap_cnt);
            edges  = 0;
            nsamp  = 0;
            slv_rx = 8'h00;
            sh     = 0;
            if (!CPHA) begin
                miso_slave = bitOf(slave_word, sel, 0);
                sh         = 1;
            end
        end else if (!ss_o && (sck_o !== prev_sck)) begin
            edges++;
            if ((prev_sck == CPOL) == !CPHA) begin
                if (nsamp < 8) slv_rx[sel ? nsamp : 7 - nsamp] = mosi_o;
                nsamp++;
            end else begin
                if (sh < 8) miso_slave = bitOf(slave_word, sel, sh);
                sh++;
            end
        end
        if (!prev_ss && ss_o) begin
            slv_q.push_back(slv_rx);
            edge_q.push_back(edges);
            seen_rise = 1'b1;
            gap_cnt   = 0;
        end
        if (ss_o) gap_cnt++;
        prev_ss  = ss_o;
        prev_sck = sck_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
    endtask

    task automatic waitIdle();
        for (int t = 0; t < 4000; t++) begin
            if (busy_o === 1'b0) break;
            @(negedge PCLK);
        end
        checkOutput("busy_clear", busy_o, 0);
    endtask

    task automatic waitEdges(input int want);
        int   n;
        logic prev;
        n    = 0;
        prev = sck_o;
        for (int t = 0; t < 1000 && n < want; t++) begin
            @(negedge PCLK);
            if (sck_o !== prev) n++;
            prev = sck_o;
        end
        checkOutput("edge_wait", n, want);
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] sw, input bit lb);
        int         b_rx, b_slv, b_edge;
        bit         ok;
        logic [7:0] exp;
        slave_word = sw;
        loopback   = lb;
        b_rx   = rx_q.size();
        b_slv  = slv_q.size();
        b_edge = edge_q.size();
        txd = tx;
        txv = 1'b1;
        waitReady(ok);
        checkOutput("accepted", 32'(ok), 1);
        @(negedge PCLK);
        txv = 1'b0;
        waitIdle();
        @(negedge PCLK);
        exp = lb ? tx : sw;
        checkOutput("rx_pulses", rx_q.size() - b_rx, 1);
        checkOutput("rx_word", rx_q[b_rx], exp);
        checkOutput("rx_hold", rxd_o, exp);
        checkOutput("ss_windows", slv_q.size() - b_slv, 1);
        checkOutput("slave_word", slv_q[b_slv], tx);
        checkOutput("sck_edges", edge_q[b_edge], 16);
        checkOutput("ss_idle", ss_o, 1);
    endtask

    task automatic setMode(input bit pol, input bit pha, input int hp);
        CPOL = pol;
        CPHA = pha;
        half = hp;
        @(negedge PCLK);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int b_rx, b_edge, b_gap;
        PRESET = 1'b1; SPE = 1'b1; CPOL = 1'b0; CPHA = 1'b0;
        txv = 1'b0; txd = 8'h00; sel = 1'b0; loopback = 1'b1; slave_word = 8'h00;
        repeat (3) @(negedge PCLK);
        checkOutput("rst_ss_n", ss_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_mosi", mosi_o, 0);
        checkOutput("rst_rx_data", rxd_o, 0);
        checkOutput("rst_rx_valid", rxv_o, 0);
        checkOutput("rst_sck_out", sck_o, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("idle_ready", ready_o, 1);

        $display("[TB] mode 0 loopback 0xA5");
        setMode(1'b0, 1'b0, 4);
        applyStimulus(8'hA5, 8'h00, 1'b1);

        $display("[TB] SPE abort after 5 edges");
        b_rx = rx_q.size();
        txd = 8'h5A; txv = 1'b1;
        waitReady(ok);
        @(negedge PCLK);
        txv = 1'b0;
        waitEdges(5);
        SPE = 1'b0;
        @(negedge PCLK);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_ss_n", ss_o, 1);
        checkOutput("abort_sck_out", sck_o, 0);
        checkOutput("abort_rx_data", rxd_o, 8'hA5);
        checkOutput("spe_off_ready", ready_o, 0);
        txv = 1'b1;
        repeat (4) @(negedge PCLK);
        checkOutput("spe_off_no_accept", busy_o, 0);
        txv = 1'b0;
        SPE = 1'b1;
        repeat (2) @(negedge PCLK);
        checkOutput("abort_no_rx_valid", rx_q.size() - b_rx, 0);

        $display("[TB] mode 3 slave 0x3C");
        setMode(1'b1, 1'b1, 3);
        applyStimulus(8'hC3, 8'h3C, 1'b0);

        $display("[TB] back-to-back 0x11 0x22");
        setMode(1'b0, 1'b0, 2);
        loopback = 1'b1;
        b_rx   = rx_q.size();
        b_edge = edge_q.size();
        b_gap  = gap_q.size();
        txd = 8'h11; txv = 1'b1;
        waitReady(ok);
        @(negedge PCLK);
        txd = 8'h22;
        waitReady(ok);
        checkOutput("b2b_second_accept", 32'(ok), 1);
        @(negedge PCLK);
        txv = 1'b0;
        waitIdle();
        @(negedge PCLK);
        checkOutput("b2b_rx_pulses", rx_q.size() - b_rx, 2);
        checkOutput("b2b_rx_first", rx_q[b_rx], 8'h11);
        checkOutput("b2b_rx_second", rx_q[b_rx+1], 8'h22);
        checkOutput("b2b_edges_second", edge_q[b_edge+1], 16);
        checkOutput("b2b_gap_count", gap_q.size() - b_gap, 2);
        checkOutput("b2b_ss_gap", gap_q[b_gap+1], 1);

        $display("[TB] reset mid-transfer in mode 2");
        setMode(1'b1, 1'b0, 2);
        txd = 8'hF0; txv = 1'b1;
        waitReady(ok);
        @(negedge PCLK);
        txv = 1'b0;
        waitEdges(3);
        PRESET = 1'b1;
        @(negedge PCLK);
        checkOutput("mid_rst_ss_n", ss_o, 1);
        checkOutput("mid_rst_busy", busy_o, 0);
        checkOutput("mid_rst_mosi", mosi_o, 0);
        checkOutput("mid_rst_rx_data", rxd_o, 0);
        checkOutput("mid_rst_sck_out", sck_o, 1);
        PRESET = 1'b0;
        @(negedge PCLK);

        $display("[TB] LSB-first mode 1 loopback 0x01");
        sel = 1'b1;
        setMode(1'b0, 1'b1, 3);
        applyStimulus(8'h01, 8'h00, 1'b1);
        checkOutput("lsb_mosi_hold", mosi_o, 0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
